svm_score: RTL

- Consumer at the other end of the normalized HOG feature stream (`fea`/`o_valid`).
- Takes one 12-bit unsigned feature per valid cycle, 36 features per block.
- Fetches the matching signed SVM weight from an external synchronous ROM and multiply-accumulates over one detection window.
- Emits the window score plus a detect flag; feeds the detection/NMS logic.

---
 rtl/svm_score.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/svm_score.sv
// svm_score: streaming SVM window scorer, feature x ROM weight MAC over one window.
// Define SVM_SAT_EN for saturating accumulate and bias add instead of wrap.
module svm_score #(
  parameter int FEA_W       = 12,
  parameter int W_W         = 12,
  parameter int ACC_W       = 32,
  parameter int FEA_PER_BLK = 36,
  parameter int BLK_PER_WIN = 105,
  parameter int WADDR_W     = 12,
  parameter logic signed [ACC_W-1:0] BIAS = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic [FEA_W-1:0]   fea,
  input  logic               i_valid,
  output logic [WADDR_W-1:0] w_addr,
  input  logic [W_W-1:0]     w_data,
  output logic [ACC_W-1:0]   score,
  output logic               detect,
  output logic               o_valid,
  output logic               busy
);

  localparam int PW   = FEA_W + W_W + 1;
  localparam int FI_W = $clog2(FEA_PER_BLK);
  localparam int BI_W = $clog2(BLK_PER_WIN);

  logic [WADDR_W-1:0] waddr_q, waddr_d;
  logic [FI_W-1:0]    fea_idx_q, fea_idx_d;
  logic [BI_W-1:0]    blk_idx_q, blk_idx_d;

  logic             v1_q, v1_d, first1_q, first1_d, last1_q, last1_d;
  logic [FEA_W-1:0] fea1_q, fea1_d;
  logic             v2_q, v2_d, first2_q, first2_d, last2_q, last2_d;
  logic [PW-1:0]    p2_q, p2_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] score_q, score_d;
  logic             detect_q, detect_d;
  logic             o_valid_q, o_valid_d;
  logic             busy_q, busy_d;

  logic             accept, first_fea, last_fea, fin;
  logic [PW-1:0]    prod;
  logic [ACC_W-1:0] term, sum, score_calc;

  function automatic logic [ACC_W-1:0] acc_add(
    input logic [ACC_W-1:0] a,
    input logic [ACC_W-1:0] b
  );
    logic [ACC_W-1:0] s;
    s = a + b;
`ifdef SVM_SAT_EN
    // overflow only when both operands share a sign the sum lost
    if (a[ACC_W-1] == b[ACC_W-1] && s[ACC_W-1] != a[ACC_W-1])
      s = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                     : {1'b0, {(ACC_W-1){1'b1}}};
`endif
    return s;
  endfunction

  assign accept    = i_valid & ~clear;
  assign first_fea = (waddr_q == '0);
  assign last_fea  = (fea_idx_q == FI_W'(FEA_PER_BLK - 1)) &&
                     (blk_idx_q == BI_W'(BLK_PER_WIN - 1));

  always_comb begin
    waddr_d   = waddr_q;
    fea_idx_d = fea_idx_q;
    blk_idx_d = blk_idx_q;
    if (clear || (i_valid && last_fea)) begin
      waddr_d   = '0;
      fea_idx_d = '0;
      blk_idx_d = '0;
    end else if (i_valid) begin
      waddr_d = waddr_q + WADDR_W'(1);
      if (fea_idx_q == FI_W'(FEA_PER_BLK - 1)) begin
        fea_idx_d = '0;
        blk_idx_d = blk_idx_q + BI_W'(1);
      end else begin
        fea_idx_d = fea_idx_q + FI_W'(1);
      end
    end
  end

  always_comb begin
    v1_d     = accept;
    fea1_d   = accept ? fea : fea1_q;
    first1_d = accept & first_fea;
    last1_d  = accept & last_fea;

    prod = $signed({{(PW-FEA_W){1'b0}}, fea1_q}) *
           $signed({{(PW-W_W){w_data[W_W-1]}}, w_data});
    v2_d     = v1_q & ~clear;
    p2_d     = v1_q ? prod : p2_q;
    first2_d = v1_q & first1_q & ~clear;
    last2_d  = v1_q & last1_q & ~clear;

    // first tag travels with the term, so a new window never reads old acc
    term  = {{(ACC_W-PW){p2_q[PW-1]}}, p2_q};
    sum   = first2_q ? term : acc_add(acc_q, term);
    acc_d = v2_q ? sum : acc_q;

    fin        = v2_q & last2_q & ~clear;
    score_calc = acc_add(sum, BIAS);
    score_d    = fin ? score_calc : score_q;
    detect_d   = fin ? (~score_calc[ACC_W-1] & (|score_calc)) : detect_q;
    o_valid_d  = fin;

    busy_d = busy_q;
    if (clear)       busy_d = 1'b0;
    else if (accept) busy_d = 1'b1;
    else if (fin)    busy_d = v1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waddr_q   <= '0;
      fea_idx_q <= '0;
      blk_idx_q <= '0;
      v1_q      <= 1'b0;
      fea1_q    <= '0;
      first1_q  <= 1'b0;
      last1_q   <= 1'b0;
      v2_q      <= 1'b0;
      p2_q      <= '0;
      first2_q  <= 1'b0;
      last2_q   <= 1'b0;
      acc_q     <= '0;
      score_q   <= '0;
      detect_q  <= 1'b0;
      o_valid_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      waddr_q   <= waddr_d;
      fea_idx_q <= fea_idx_d;
      blk_idx_q <= blk_idx_d;
      v1_q      <= v1_d;
      fea1_q    <= fea1_d;
      first1_q  <= first1_d;
      last1_q   <= last1_d;
      v2_q      <= v2_d;
      p2_q      <= p2_d;
      first2_q  <= first2_d;
      last2_q   <= last2_d;
      acc_q     <= acc_d;
      score_q   <= score_d;
      detect_q  <= detect_d;
      o_valid_q <= o_valid_d;
      busy_q    <= busy_d;
    end
  end

  assign w_addr  = waddr_q;
  assign score   = score_q;
  assign detect  = detect_q;
  assign o_valid = o_valid_q;
  assign busy    = busy_q;

endmodule
